// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester handshakes plus RAM-side bus of ram_port_arbiter.
interface ram_port_arbiter_if #(parameter int ADDR_W = 5, parameter int DATA_W = 4);
    logic              clr, wr_req, wr_ack, rd_req, rd_ack, rd_valid;
    logic              ram_wren, ram_rden, full;
    logic [DATA_W-1:0] wr_data, rd_data, ram_data, ram_q;
    logic [ADDR_W-1:0] rd_addr, ram_wraddress, ram_rdaddress, wr_ptr;
    modport master (
        output clr, wr_req, wr_data, rd_req, rd_addr, ram_q,
        input  wr_ack, rd_ack, rd_data, rd_valid, ram_wren, ram_wraddress, ram_data,
               ram_rden, ram_rdaddress, wr_ptr, full
    );
    modport slave (
        input  clr, wr_req, wr_data, rd_req, rd_addr, ram_q,
        output wr_ack, rd_ack, rd_data, rd_valid, ram_wren, ram_wraddress, ram_data,
               ram_rden, ram_rdaddress, wr_ptr, full
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the message RAM between the UART writer and the display reader.
// Define ARB_RR_EN for round-robin conflict resolution; otherwise writes win.
module ram_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
) (
    input  logic              CLOCK_50,
    input  logic              Reset_n,
    ram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, RD_WAIT} state_t;
    state_t state, state_n;
    logic   wr_elig, grant_wr, grant_rd;
`ifdef ARB_RR_EN
    logic   last_wr;
`endif
    assign wr_elig = bus.wr_req & ~bus.full;
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        state_n  = IDLE;
        case (state)
            IDLE: begin
`ifdef ARB_RR_EN
                grant_wr = ~bus.clr & wr_elig & (~bus.rd_req | ~last_wr);
`else
                grant_wr = ~bus.clr & wr_elig;
`endif
                grant_rd = ~bus.clr & bus.rd_req & ~grant_wr;
                state_n  = grant_wr ? WRITE : grant_rd ? READ : IDLE;
            end
            READ:    state_n = RD_WAIT;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            state             <= IDLE;
            bus.wr_ack        <= 1'b0;
            bus.rd_ack        <= 1'b0;
            bus.rd_valid      <= 1'b0;
            bus.rd_data       <= '0;
            bus.ram_wren      <= 1'b0;
            bus.ram_wraddress <= '0;
            bus.ram_data      <= '0;
            bus.ram_rden      <= 1'b0;
            bus.ram_rdaddress <= '0;
            bus.wr_ptr        <= '0;
            bus.full          <= 1'b0;
`ifdef ARB_RR_EN
            last_wr           <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            bus.wr_ack   <= grant_wr;
            bus.ram_wren <= grant_wr;
            bus.rd_ack   <= grant_rd;
            bus.ram_rden <= grant_rd;
            bus.rd_valid <= state == RD_WAIT;
            if (grant_wr) begin
                bus.ram_wraddress <= bus.wr_ptr;
                bus.ram_data      <= bus.wr_data;
            end
            if (grant_rd)
                bus.ram_rdaddress <= bus.rd_addr;
            if (state == RD_WAIT)
                bus.rd_data <= bus.ram_q;
`ifdef ARB_RR_EN
            if (grant_wr | grant_rd)
                last_wr <= grant_wr;
`endif
            // clear outranks the pointer advance of a write completing in the same cycle
            if (bus.clr) begin
                bus.wr_ptr <= '0;
                bus.full   <= 1'b0;
            end else if (state == WRITE) begin
                bus.wr_ptr <= bus.wr_ptr + 1'b1;
                if (&bus.wr_ptr)
                    bus.full <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: vector table, directed corner sequences and random ops vs a RAM/pointer model.
module tb_ram_port_arbiter;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk = 1'b0;
    logic Reset_n = 1'b0;
    int   tests = 0, fails = 0;
    int   wack_cnt = 0, rvalid_cnt = 0, overlap = 0;
    logic [3:0] mem [32];

    ram_port_arbiter_if #(.ADDR_W(5), .DATA_W(4)) bus ();
    ram_port_arbiter #(.ADDR_W(5), .DATA_W(4)) dut (.CLOCK_50(clk), .Reset_n(Reset_n), .bus(bus));

    always #5 clk = ~clk;

    // behavioural RAM: write at the edge, registered read one edge later
    always @(posedge clk) begin
        if (bus.ram_wren) mem[bus.ram_wraddress] <= bus.ram_data;
        if (bus.ram_rden) bus.ram_q <= mem[bus.ram_rdaddress];
    end

    always @(negedge clk) begin
        if (bus.wr_ack) wack_cnt <= wack_cnt + 1;
        if (bus.rd_valid) rvalid_cnt <= rvalid_cnt + 1;
        if ((bus.ram_wren && bus.ram_rden) || (bus.wr_ack && bus.rd_ack)) overlap <= overlap + 1;
    end

    typedef struct {
        bit         is_rd;
        logic [4:0] a;
        logic [3:0] d;
        logic [3:0] exp_q;
        logic [4:0] exp_ptr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check(name, {bus.wr_ack, bus.rd_ack, bus.rd_valid, bus.ram_wren, bus.ram_rden, bus.full,
                     bus.rd_data, bus.ram_data, bus.wr_ptr, bus.ram_wraddress, bus.ram_rdaddress}, 0);
    endtask

    task automatic do_write(input logic [3:0] d, input int max, output bit acked, output int lat);
        @(negedge clk);
        bus.wr_data = d;
        bus.wr_req  = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.wr_ack && lat < max);
        acked = bus.wr_ack;
        bus.wr_req = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a, output logic [3:0] q, output int lat, output int vl);
        @(negedge clk);
        bus.rd_addr = a;
        bus.rd_req  = 1'b1;
        lat = 0;
        vl  = 0;
        q   = 'x;
        do begin @(negedge clk); lat++; end while (!bus.rd_ack && lat < 8);
        bus.rd_req = 1'b0;
        if (!bus.rd_ack) return;
        do begin @(negedge clk); vl++; end while (!bus.rd_valid && vl < 8);
        q = bus.rd_data;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset_n = 1'b0;
        repeat (2) @(negedge clk);
        Reset_n = 1'b1;
    endtask

    initial begin
        vec_t       v [6];
        bit         acked;
        int         lat, vl, n, prev, bad, cnt0;
        logic [3:0] q;
        logic [3:0] mm [32];
        bit         mv [32];
        int         mp, nvalid;
        bit         mf;
        logic [4:0] a;
        logic [3:0] d;

        v[0] = '{0, 5'd0, 4'h1, 4'h0, 5'd1};
        v[1] = '{0, 5'd0, 4'h2, 4'h0, 5'd2};
        v[2] = '{0, 5'd0, 4'h3, 4'h0, 5'd3};
        v[3] = '{1, 5'd1, 4'h0, 4'h2, 5'd3};
        v[4] = '{1, 5'd0, 4'h0, 4'h1, 5'd3};
        v[5] = '{1, 5'd2, 4'h0, 4'h3, 5'd3};

        bus.clr = 0; bus.wr_req = 0; bus.wr_data = 0; bus.rd_req = 0; bus.rd_addr = 0;
        repeat (2) @(negedge clk);
        check_zero("reset_state");
        Reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            if (v[i].is_rd) begin
                do_read(v[i].a, q, lat, vl);
                check("tbl_rd_data", q, v[i].exp_q);
                check("tbl_rd_ack_lat", lat, 1);
                check("tbl_rd_valid_lat", vl, 2);
            end else begin
                do_write(v[i].d, 6, acked, lat);
                check("tbl_wr_ack", acked, 1);
                check("tbl_wr_ack_lat", lat, 1);
            end
            @(negedge clk);
            check("tbl_wr_ptr", bus.wr_ptr, v[i].exp_ptr);
            check("tbl_full", bus.full, 0);
        end
        check("rd_data_hold", bus.rd_data, 4'h3);
        check("rd_valid_one_cycle", bus.rd_valid, 0);

        // fill all 32 locations with a continuously held request
        pulse_clr();
        bus.wr_data = 4'h0;
        bus.wr_req  = 1'b1;
        n = 0; prev = 0; bad = 0;
        for (int c = 0; c < 200 && n < 32; c++) begin
            @(negedge clk);
            if (bus.wr_ack) begin
                if (n > 0 && c - prev != 2) bad++;
                prev = c;
                n++;
                bus.wr_data = 4'(n);
            end
        end
        bus.wr_req = 1'b0;
        check("fill_count", n, 32);
        check("fill_ack_spacing", bad, 0);
        @(negedge clk);
        check("fill_full", bus.full, 1);
        check("fill_wr_ptr", bus.wr_ptr, 0);

        cnt0 = wack_cnt;
        bus.wr_data = 4'h5;
        bus.wr_req  = 1'b1;
        do_read(5'd31, q, lat, vl);
        check("full_read31", q, 4'hF);
        repeat (16) @(negedge clk);
        bus.wr_req = 1'b0;
        check("full_stall_no_ack", wack_cnt - cnt0, 0);
        check("full_still_set", bus.full, 1);

        pulse_clr();
        check("clr_full", bus.full, 0);
        check("clr_wr_ptr", bus.wr_ptr, 0);
        for (int i = 0; i < 5; i++) do_write(4'(9 + i), 6, acked, lat);
        @(negedge clk);
        check("pre_clr_ptr", bus.wr_ptr, 5);

        // clr lands in the WRITE cycle to address 5
        bus.wr_data = 4'h7;
        bus.wr_req  = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.wr_ack && n < 6);
        check("clr_mid_ack", bus.wr_ack, 1);
        bus.clr    = 1'b1;
        bus.wr_req = 1'b0;
        @(negedge clk);
        bus.clr = 1'b0;
        check("clr_mid_ptr", bus.wr_ptr, 0);
        check("clr_mid_full", bus.full, 0);
        do_read(5'd5, q, lat, vl);
        check("clr_mid_ram5", q, 4'h7);
        do_write(4'h3, 6, acked, lat);
        @(negedge clk);
        check("post_clr_ptr", bus.wr_ptr, 1);
        do_read(5'd0, q, lat, vl);
        check("post_clr_ram0", q, 4'h3);

        // reset while in RD_WAIT
        @(negedge clk);
        bus.rd_addr = 5'd0;
        bus.rd_req  = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rd_ack && n < 6);
        bus.rd_req = 1'b0;
        check("rst_rd_ack", bus.rd_ack, 1);
        @(negedge clk);
        Reset_n = 1'b0;
        #1;
        check_zero("rst_mid_outputs");
        cnt0 = rvalid_cnt;
        @(negedge clk);
        Reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_no_valid", rvalid_cnt - cnt0, 0);

        // both requesters held, starting from reset (last grant = READ)
        bus.wr_data = 4'hA;
        bus.rd_addr = 5'd0;
        bus.wr_req  = 1'b1;
        bus.rd_req  = 1'b1;
        n = 0;
        for (int c = 0; c < 60 && n < 8; c++) begin
            @(negedge clk);
            if (bus.wr_ack || bus.rd_ack) begin
                check("arb_grant_is_write", bus.wr_ack, RR ? (n % 2 == 0) : 1);
                n++;
            end
        end
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        check("arb_grant_count", n, 8);
        repeat (4) @(negedge clk);

        // random ops vs model: RAM contents, pointer and sticky full
        do_reset();
        mp = 0; mf = 0; nvalid = 0;
        for (int i = 0; i < 32; i++) mv[i] = 0;
        for (int i = 0; i < 250; i++) begin
            n = int'($urandom_range(0, 99));
            if (n < 1) begin
                pulse_clr();
                mp = 0;
                mf = 0;
            end else if (n < 55 || nvalid == 0) begin
                d = 4'($urandom);
                if (mf) begin
                    do_write(d, 4, acked, lat);
                    check("rnd_full_no_ack", acked, 0);
                end else begin
                    do_write(d, 6, acked, lat);
                    check("rnd_wr_ack", acked, 1);
                    if (!mv[mp]) nvalid++;
                    mm[mp] = d;
                    mv[mp] = 1;
                    if (mp == 31) mf = 1;
                    mp = (mp + 1) % 32;
                end
            end else begin
                do a = 5'($urandom); while (!mv[a]);
                do_read(a, q, lat, vl);
                check("rnd_rd_data", q, mm[a]);
                check("rnd_rd_lat", lat + vl, 3);
            end
            @(negedge clk);
            check("rnd_wr_ptr", bus.wr_ptr, mp);
            check("rnd_full", bus.full, mf);
        end

        check("never_both_enables", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
